// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Control sequencer for the multi-cycle RV32I core. Optional
//               retired-instruction counter enabled by MCFSM_INSTRET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int OPC_W   = 7,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic [STATE_W-1:0] state,
    output logic               illegal,
    output logic [31:0]        instret
);

    localparam logic [STATE_W-1:0] c_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_EXEC     = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_ALU_WB   = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_MEM_ADDR = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_MEM_ACC  = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_LOAD_WB  = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_BRANCH   = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_JAL      = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_HALT     = STATE_W'(9);

    localparam logic [OPC_W-1:0] c_OP_R     = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] c_OP_I     = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] c_OP_LOAD  = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] c_OP_STORE = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] c_OP_BR    = OPC_W'(7'b1100011);
    localparam logic [OPC_W-1:0] c_OP_JAL   = OPC_W'(7'b1101111);
    localparam logic [OPC_W-1:0] c_OP_LUI   = OPC_W'(7'b0110111);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               r_illegal;
    logic               w_is_store;
    logic               w_is_lui;
    logic               w_unused;

    // ALU function decode lives in the datapath, so funct fields only pass by here.
    assign w_unused   = ^{funct3, funct7};
    assign w_is_store = (opcode == c_OP_STORE);
    assign w_is_lui   = (opcode == c_OP_LUI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            if ((r_state == c_DECODE) && (w_next == c_HALT))
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:    if (mem_ready) w_next = c_DECODE;
            c_DECODE: begin
                case (opcode)
                    c_OP_R, c_OP_I:         w_next = c_EXEC;
                    c_OP_LOAD, c_OP_STORE:  w_next = c_MEM_ADDR;
                    c_OP_BR:                w_next = c_BRANCH;
                    c_OP_JAL:               w_next = c_JAL;
                    c_OP_LUI:               w_next = c_ALU_WB;
                    default:                w_next = c_HALT;
                endcase
            end
            c_EXEC:     w_next = c_ALU_WB;
            c_MEM_ADDR: w_next = c_MEM_ACC;
            c_MEM_ACC:  if (mem_ready) w_next = w_is_store ? c_FETCH : c_LOAD_WB;
            c_ALU_WB, c_LOAD_WB, c_BRANCH, c_JAL: w_next = c_FETCH;
            c_HALT:     w_next = c_HALT;
            default:    w_next = c_FETCH;
        endcase
    end

    // Reset masks every output so an aborted access leaves nothing behind.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        state     = '0;
        illegal   = 1'b0;
        if (!reset) begin
            state   = r_state;
            illegal = r_illegal;
            case (r_state)
                c_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                c_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                c_EXEC: begin
                    alu_src_a = 2'b10;
                    alu_src_b = (opcode == c_OP_R) ? 2'b00 : 2'b10;
                    alu_op    = 2'b10;
                end
                c_ALU_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = w_is_lui ? 2'b11 : 2'b00;
                end
                c_MEM_ADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                c_MEM_ACC: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = w_is_store;
                end
                c_LOAD_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b01;
                end
                c_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_write  = branch_taken;
                end
                c_JAL: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                    pc_write  = 1'b1;
                    pc_src    = 2'b01;
                end
                default: ;
            endcase
        end
    end

`ifdef MCFSM_INSTRET_EN
    logic [31:0] r_instret;
    logic        w_retire;

    assign w_retire = (r_state == c_ALU_WB) || (r_state == c_LOAD_WB) ||
                      (r_state == c_BRANCH) || (r_state == c_JAL) ||
                      ((r_state == c_MEM_ACC) && w_is_store && mem_ready);

    always_ff @(posedge clk) begin
        if (reset)
            r_instret <= '0;
        else if (w_retire)
            r_instret <= r_instret + 32'd1;
    end

    assign instret = reset ? 32'd0 : r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule
`default_nettype wire
